// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU control codes and datapath select values.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    StReset, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBranch, StJal, StLui, StIllegal
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpNone  = 2'b11
  } alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b1110;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluNone = 4'b0000;

  localparam logic [2:0] ExtI = 3'b000;
  localparam logic [2:0] ExtS = 3'b001;
  localparam logic [2:0] ExtB = 3'b010;
  localparam logic [2:0] ExtJ = 3'b011;
  localparam logic [2:0] ExtU = 3'b100;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;
  localparam logic [1:0] ResImm    = 2'b11;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [2:0] ext_sel(input logic [6:0] op);
    case (op)
      OpStore:  ext_sel = ExtS;
      OpBranch: ext_sel = ExtB;
      OpJal:    ext_sel = ExtJ;
      OpLui:    ext_sel = ExtU;
      default:  ext_sel = ExtI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode; funct_ok flags funct3 values the ALU
// decode supports, regardless of the requested operation.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_r,
  output logic [3:0] alu_control,
  output logic       funct_ok
);

  always_comb begin
    funct_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
    alu_control = AluNone;
    unique case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct3)
          3'b000:  alu_control = (op_r && funct7_5) ? AluSub : AluAdd;
          3'b111:  alu_control = AluAnd;
          3'b110:  alu_control = AluOr;
          default: alu_control = AluNone;
        endcase
      end
      AluOpNone: alu_control = AluNone;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing each RV32I instruction through the shared datapath,
// with optional memory wait handshake, sticky illegal flag and retire count.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             adr_src,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [1:0]       sel_alu_src_a,
  output logic [1:0]       sel_alu_src_b,
  output logic [3:0]       alu_control,
  output logic [2:0]       sel_ext,
  output logic [1:0]       sel_result,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired
);

  state_e           state_q, state_d;
  alu_op_e          alu_op;
  logic             funct_ok;
  logic             mem_ok;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  assign mem_ok = !MEM_WAIT_EN || mem_ready;

  multicycle_controller_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op_r        (state_q == StExecR),
    .alu_control (alu_control),
    .funct_ok    (funct_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: if (mem_ok) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = (funct3 == 3'b010) ? StMemAdr : StIllegal;
          OpR:             state_d = funct_ok ? StExecR : StIllegal;
          OpI:             state_d = funct_ok ? StExecI : StIllegal;
          OpBranch:        state_d = (funct3[2:1] == 2'b00) ? StBranch : StIllegal;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ok) state_d = StMemWb;
      StMemWrite: if (mem_ok) state_d = StFetch;
      StMemWb, StAluWb, StBranch, StLui: state_d = StFetch;
      StExecR, StExecI, StJal:           state_d = StAluWb;
      StIllegal:  state_d = StIllegal;
      default:    state_d = StReset;
    endcase
  end

  always_comb begin
    pc_we         = 1'b0;
    ir_we         = 1'b0;
    adr_src       = 1'b0;
    dmem_we       = 1'b0;
    rf_we         = 1'b0;
    sel_alu_src_a = SrcAPc;
    sel_alu_src_b = SrcBRs2;
    sel_result    = ResAluOut;
    alu_op        = AluOpNone;
    sel_ext       = ext_sel(opcode);
    unique case (state_q)
      StFetch: begin
        ir_we         = mem_ok;
        pc_we         = mem_ok;
        sel_alu_src_b = SrcBFour;
        alu_op        = AluOpAdd;
        sel_result    = ResAluRes;
      end
      StDecode: begin
        sel_alu_src_a = SrcAOldPc;
        sel_alu_src_b = SrcBImm;
        alu_op        = AluOpAdd;
      end
      StMemAdr: begin
        sel_alu_src_a = SrcARs1;
        sel_alu_src_b = SrcBImm;
        alu_op        = AluOpAdd;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        sel_result = ResMem;
        rf_we      = 1'b1;
      end
      StMemWrite: begin
        adr_src = 1'b1;
        dmem_we = 1'b1;
      end
      StExecR: begin
        sel_alu_src_a = SrcARs1;
        alu_op        = AluOpFunct;
      end
      StExecI: begin
        sel_alu_src_a = SrcARs1;
        sel_alu_src_b = SrcBImm;
        alu_op        = AluOpFunct;
      end
      StAluWb: rf_we = 1'b1;
      StBranch: begin
        sel_alu_src_a = SrcARs1;
        alu_op        = AluOpSub;
        pc_we         = zero ^ funct3[0];
      end
      StJal: begin
        sel_alu_src_a = SrcAOldPc;
        sel_alu_src_b = SrcBFour;
        alu_op        = AluOpAdd;
        pc_we         = 1'b1;
      end
      StLui: begin
        sel_result = ResImm;
        rf_we      = 1'b1;
      end
      default: ;
    endcase
  end

  // A FETCH hold is not a new retirement, nor is the first FETCH after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= illegal_q | (state_d == StIllegal);
      if (state_d == StFetch && state_q != StFetch && state_q != StReset) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign illegal       = illegal_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-cycle expected output vectors go through a scoreboard
// queue and are compared at the falling edge against two controller instances.
module tb_multicycle_controller;

  typedef logic [18:0] ov_t;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b1110;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] NON = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5, zero, mem_ready;

  logic        pc_we, ir_we, adr_src, dmem_we, rf_we, illegal;
  logic [1:0]  src_a, src_b, res;
  logic [3:0]  alu;
  logic [2:0]  ext;
  logic [3:0]  cnt;
  logic        pc_we0, ir_we0, adr_src0, dmem_we0, rf_we0, illegal0;
  logic [1:0]  src_a0, src_b0, res0;
  logic [3:0]  alu0;
  logic [2:0]  ext0;
  logic [31:0] cnt0;

  ov_t         obs, obs0;
  ov_t         exp_q[$];
  logic [2:0]  x;
  logic [3:0]  exp_cnt;
  logic [31:0] exp_cnt0;
  logic        chk0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_EN(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src),
    .dmem_we(dmem_we), .rf_we(rf_we), .sel_alu_src_a(src_a), .sel_alu_src_b(src_b),
    .alu_control(alu), .sel_ext(ext), .sel_result(res), .illegal(illegal),
    .instr_retired(cnt)
  );

  // Default instance: mem_ready tied low must be ignored.
  multicycle_controller u_dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(1'b0), .pc_we(pc_we0), .ir_we(ir_we0), .adr_src(adr_src0),
    .dmem_we(dmem_we0), .rf_we(rf_we0), .sel_alu_src_a(src_a0), .sel_alu_src_b(src_b0),
    .alu_control(alu0), .sel_ext(ext0), .sel_result(res0), .illegal(illegal0),
    .instr_retired(cnt0)
  );

  assign obs  = {pc_we, ir_we, adr_src, dmem_we, rf_we, src_a, src_b, alu, ext, res, illegal};
  assign obs0 = {pc_we0, ir_we0, adr_src0, dmem_we0, rf_we0, src_a0, src_b0, alu0, ext0, res0,
                 illegal0};

  function automatic ov_t ev(input logic pc, ir, adr, dwe, rwe, input logic [1:0] a, b,
                             input logic [3:0] op, input logic [2:0] e, input logic [1:0] r,
                             input logic ill);
    return {pc, ir, adr, dwe, rwe, a, b, op, e, r, ill};
  endfunction

  function automatic logic [2:0] ext_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  task automatic cyc(input ov_t e, input string tag);
    ov_t want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, want);
    end
    if (chk0) begin
      checks++;
      assert (obs0 === want) else begin
        errors++;
        $error("FAIL %s_nowait observed %h expected %h", tag, obs0, want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    checks++;
    assert (cnt === exp_cnt) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, cnt, exp_cnt);
    end
    if (chk0) begin
      checks++;
      assert (cnt0 === exp_cnt0) else begin
        errors++;
        $error("FAIL %s_nowait observed %0d expected %0d", tag, cnt0, exp_cnt0);
      end
    end
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode = op; funct3 = f3; funct7_5 = f75; x = ext_of(op);
  endtask

  task automatic fetch_decode();
    cyc(ev(1, 1, 0, 0, 0, 2'b00, 2'b10, ADD, x, 2'b10, 0), "fetch");
    chk_cnt("count");
    cyc(ev(0, 0, 0, 0, 0, 2'b01, 2'b01, ADD, x, 2'b00, 0), "decode");
  endtask

  task automatic retire();
    exp_cnt++;
    exp_cnt0++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, NON, x, 2'b00, 0), "reset_abort");
    exp_cnt = '0; exp_cnt0 = '0;
    chk_cnt("reset_count");
    rst_n = 1'b1;
    cyc(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, NON, x, 2'b00, 0), "reset_state");
  endtask

  task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic [3:0] a_op);
    set_ins(op, f3, f75);
    fetch_decode();
    cyc(ev(0, 0, 0, 0, 0, 2'b10, (op == 7'b0110011) ? 2'b00 : 2'b01, a_op, x, 2'b00, 0),
        "exec");
    cyc(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, NON, x, 2'b00, 0), "aluwb");
    retire();
  endtask

  task automatic branch(input logic [2:0] f3, input logic z, input logic pc);
    set_ins(7'b1100011, f3, 1'b0);
    zero = z;
    fetch_decode();
    cyc(ev(pc, 0, 0, 0, 0, 2'b10, 2'b00, SUB, x, 2'b00, 0), "branch");
    retire();
  endtask

  task automatic lui();
    set_ins(7'b0110111, 3'b000, 1'b0);
    fetch_decode();
    cyc(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, NON, x, 2'b11, 0), "lui");
    retire();
  endtask

  initial begin
    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b1; chk0 = 1'b1;
    exp_cnt = '0; exp_cnt0 = '0;
    set_ins(7'b0000000, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, NON, x, 2'b00, 0), "in_reset");
    chk_cnt("reset_count");
    rst_n = 1'b1;
    cyc(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, NON, x, 2'b00, 0), "reset_state");

    alu_instr(7'b0110011, 3'b000, 1'b1, SUB);
    alu_instr(7'b0010011, 3'b000, 1'b1, ADD);
    alu_instr(7'b0110011, 3'b111, 1'b0, AND);
    alu_instr(7'b0010011, 3'b110, 1'b0, OR);
    branch(3'b000, 1'b1, 1'b1);
    branch(3'b001, 1'b1, 1'b0);
    branch(3'b000, 1'b0, 1'b0);

    set_ins(7'b1101111, 3'b000, 1'b0);
    fetch_decode();
    cyc(ev(1, 0, 0, 0, 0, 2'b01, 2'b10, ADD, x, 2'b00, 0), "jal");
    cyc(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, NON, x, 2'b00, 0), "jal_link");
    retire();
    lui();

    for (int w = 0; w < 2; w++) begin
      // Pass 0 without wait states; pass 1 stretches the memory access to 3 cycles.
      chk0 = (w == 0);
      set_ins(7'b0000011, 3'b010, 1'b0);
      fetch_decode();
      cyc(ev(0, 0, 0, 0, 0, 2'b10, 2'b01, ADD, x, 2'b00, 0), "lw_adr");
      for (int k = 2 * w; k >= 0; k--) begin
        mem_ready = (k == 0);
        cyc(ev(0, 0, 1, 0, 0, 2'b00, 2'b00, NON, x, 2'b00, 0), "lw_read");
      end
      cyc(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, NON, x, 2'b01, 0), "lw_wb");
      retire();

      set_ins(7'b0100011, 3'b010, 1'b0);
      if (w == 1) begin
        mem_ready = 1'b0;
        cyc(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, ADD, x, 2'b10, 0), "fetch_hold");
        mem_ready = 1'b1;
      end
      fetch_decode();
      cyc(ev(0, 0, 0, 0, 0, 2'b10, 2'b01, ADD, x, 2'b00, 0), "sw_adr");
      for (int k = 2 * w; k >= 0; k--) begin
        mem_ready = (k == 0);
        cyc(ev(0, 0, 1, 1, 0, 2'b00, 2'b00, NON, x, 2'b00, 0), "sw_write");
      end
      retire();
    end

    set_ins(7'b0000000, 3'b000, 1'b0);
    fetch_decode();
    for (int i = 0; i < 3; i++) cyc(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, NON, x, 2'b00, 1), "illegal");
    chk_cnt("illegal_count");
    do_reset();
    chk0 = 1'b1;

    // Abort an R-type while it is in ALUWB: the write enable must vanish at once.
    set_ins(7'b0110011, 3'b000, 1'b0);
    fetch_decode();
    cyc(ev(0, 0, 0, 0, 0, 2'b10, 2'b00, ADD, x, 2'b00, 0), "exec_add");
    do_reset();

    for (int i = 0; i < 16; i++) lui();
    set_ins(7'b0110111, 3'b000, 1'b0);
    cyc(ev(1, 1, 0, 0, 0, 2'b00, 2'b10, ADD, x, 2'b10, 0), "fetch");
    checks++;
    assert (cnt === 4'd0) else begin
      errors++;
      $error("FAIL wrap observed %0d expected 0", cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
